// File: rtl/mbist_march_ctrl.sv
// March-test BIST controller (MATS+, March X, March C-) for one single-port RAM,
// with selectable background, pass-through when idle and first-fail diagnostics.
module mbist_march_ctrl #(
  parameter int wcount  = 256,
  parameter int wlength = 4,
  parameter int fcw     = 8,
  localparam int aw     = (wcount > 1) ? $clog2(wcount) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic               bg_sel,
  input  logic               rwbarin,
  input  logic [wlength-1:0] datain,
  input  logic [aw-1:0]      address,
  output logic               mem_rwbar,
  output logic [wlength-1:0] mem_din,
  output logic [aw-1:0]      mem_addr,
  input  logic [wlength-1:0] mem_dout,
  output logic [wlength-1:0] dataout,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [aw-1:0]      fail_addr,
  output logic [2:0]         fail_elem,
  output logic [wlength-1:0] fail_bits,
  output logic [fcw-1:0]     fail_count,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] ALG_MATS = 2'd0;
  localparam logic [1:0] ALG_X    = 2'd1;
  localparam logic [1:0] ALG_C    = 2'd2;

  // One March element: op count, direction and the (read?, value) of each op.
  typedef struct packed {
    logic two_ops;
    logic down;
    logic rd0;
    logic val0;
    logic rd1;
    logic val1;
  } elem_t;

  function automatic elem_t elem_desc(input logic [1:0] alg, input logic [2:0] e);
    elem_t d;
    d = '0;
    if (alg == ALG_C) begin
      case (e)
        3'd1:    d = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        3'd2:    d = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        3'd3:    d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        3'd4:    d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        3'd5:    d = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        default: d = '0;
      endcase
    end else begin
      case (e)
        3'd1:    d = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        3'd2:    d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        3'd3:    d = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        default: d = '0;
      endcase
    end
    return d;
  endfunction

  function automatic logic [wlength-1:0] bg_word(input logic cb, input logic a0);
    logic [wlength-1:0] w;
    for (int i = 0; i < wlength; i++) begin
      w[i] = cb & ~(i[0] ^ a0);
    end
    return w;
  endfunction

  state_t             state;
  logic [1:0]         alg_q;
  logic               bg_q;
  logic [2:0]         elem;
  logic               op;
  logic [aw-1:0]      addr;
  logic               cmp_valid;
  logic [wlength-1:0] cmp_exp;
  logic [aw-1:0]      cmp_addr;
  logic [2:0]         cmp_elem;

  elem_t              cur_d;
  elem_t              next_d;
  logic               cur_rd;
  logic               cur_val;
  logic [wlength-1:0] cur_word;
  logic               last_op;
  logic               at_end;
  logic [2:0]         last_elem;
  logic               mismatch;

  always_comb begin
    cur_d     = elem_desc(alg_q, elem);
    next_d    = elem_desc(alg_q, elem + 3'd1);
    cur_rd    = op ? cur_d.rd1 : cur_d.rd0;
    cur_val   = op ? cur_d.val1 : cur_d.val0;
    cur_word  = bg_word(bg_q, addr[0]) ^ {wlength{cur_val}};
    last_op   = !cur_d.two_ops || op;
    at_end    = cur_d.down ? (addr == '0) : (addr == aw'(wcount - 1));
    last_elem = (alg_q == ALG_MATS) ? 3'd2 : (alg_q == ALG_X) ? 3'd3 : 3'd5;
    mismatch  = cmp_valid && (cmp_exp != mem_dout);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      alg_q      <= ALG_MATS;
      bg_q       <= 1'b0;
      elem       <= '0;
      op         <= 1'b0;
      addr       <= '0;
      cmp_valid  <= 1'b0;
      cmp_exp    <= '0;
      cmp_addr   <= '0;
      cmp_elem   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_bits  <= '0;
      fail_count <= '0;
    end else begin
      cmp_valid <= 1'b0;
      // A read issued last cycle is judged now, even while the next op issues.
      if (mismatch) begin
        if (fail_count != '1) fail_count <= fail_count + fcw'(1);
        if (!fail) begin
          fail      <= 1'b1;
          fail_addr <= cmp_addr;
          fail_elem <= cmp_elem;
          fail_bits <= cmp_exp ^ mem_dout;
        end
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_RUN;
            busy       <= 1'b1;
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_bits  <= '0;
            fail_count <= '0;
            alg_q      <= (mode == 2'd3) ? ALG_C : mode;
            bg_q       <= bg_sel;
            elem       <= '0;
            op         <= 1'b0;
            addr       <= '0;
          end
        end
        S_RUN: begin
          if (cur_rd) begin
            cmp_valid <= 1'b1;
            cmp_exp   <= cur_word;
            cmp_addr  <= addr;
            cmp_elem  <= elem;
          end
          if (!last_op) begin
            op <= 1'b1;
          end else begin
            op <= 1'b0;
            if (at_end) begin
              if (elem == last_elem) begin
                state <= S_DRAIN;
              end else begin
                elem <= elem + 3'd1;
                addr <= next_d.down ? aw'(wcount - 1) : '0;
              end
            end else begin
              addr <= cur_d.down ? addr - aw'(1) : addr + aw'(1);
            end
          end
        end
        S_DRAIN: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    if (state == S_RUN) begin
      mem_rwbar = cur_rd;
      mem_din   = cur_word;
      mem_addr  = addr;
    end else begin
      mem_rwbar = rwbarin;
      mem_din   = datain;
      mem_addr  = address;
    end
  end

  assign dataout   = mem_dout;
  assign dbg_state = state;

endmodule

// File: doc/mbist_march_ctrl.md
# mbist_march_ctrl

Parametrised March-test BIST controller for one single-port synchronous RAM of `wcount` words × `wlength` bits. It is the successor to the fixed-algorithm MBIST top, and adds three things: a run-time selectable algorithm (MATS+, March X, March C-), a selectable data background, and fail diagnostics (first-fail capture plus a saturating fail counter). It sits between the functional memory port and the RAM macro. When idle it passes functional traffic straight through; while a test runs it takes ownership of the RAM port.

## Interface
Parameters:
- `wcount`, 256, number of RAM words; need not be a power of two.
- `wlength`, 4, word width in bits.
- `fcw`, 8, width of the fail counter.

Ports (AW = $clog2(wcount)):
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  test request. Sampled only in IDLE or DONE.
- `mode`  in  2  algorithm: 00 MATS+, 01 March X, 10 March C-, 11 treated as March C-.
- `bg_sel`  in  1  background: 0 solid, 1 checkerboard.
- `rwbarin`, `datain`, `address`  in  1/wlength/AW  functional port.
- `mem_rwbar`, `mem_din`, `mem_addr`  out  1/wlength/AW  RAM port. 1 = read.
- `mem_dout`  in  wlength  RAM read data, valid the cycle after the read.
- `dataout`  out  wlength  equals `mem_dout` at all times.
- `busy`, `done`, `fail`  out  1  status.
- `fail_addr`  out  AW  address of the first mismatch.
- `fail_elem`  out  3  March element index of the first mismatch.
- `fail_bits`  out  wlength  expected XOR actual at the first mismatch.
- `fail_count`  out  fcw  number of mismatches, saturating.

## Operation
States:
- IDLE → RUN on `start`.
- RUN → DRAIN after the last op of the last element.
- DRAIN → DONE after one cycle.
- DONE → RUN on `start`.
- `start` is ignored in RUN and DRAIN.

Elements. ⇑ = ascending 0..wcount-1, ⇓ = descending wcount-1..0, ⇕ = executed ascending.
- MATS+: e0 ⇕(w0); e1 ⇑(r0,w1); e2 ⇓(r1,w0).
- March X: the MATS+ elements, then e3 ⇕(r0).
- March C-: e0 ⇕(w0); e1 ⇑(r0,w1); e2 ⇑(r1,w0); e3 ⇓(r0,w1); e4 ⇓(r1,w0); e5 ⇕(r0).

Sequencing:
- One op per cycle. An element executes all of its ops at one address before the address advances.
- There are no bubbles between elements.
- `mode` and `bg_sel` are latched when `start` is accepted.

Data values:
- "0" = background word B(addr); "1" = ~B(addr).
- Solid: B = all zeros.
- Checkerboard: bit i of B = ~i[0] ^ addr[0]. So addr 0 → 0101 and addr 1 → 1010 for `wlength`=4.

Compare:
- Each read registers its expected word, its address and its element index.
- The expected word is compared against `mem_dout` on the next cycle.
- On a mismatch, `fail_count` increments and saturates at 2^fcw-1.
- On the first mismatch of a run, `fail`=1 and `fail_addr`/`fail_elem`/`fail_bits` are captured. Later mismatches never overwrite the captured values.

Port mux:
- RUN: the controller drives the `mem_*` outputs.
- DRAIN, IDLE and DONE: combinational pass-through of `rwbarin`/`datain`/`address`.

Accepting `start` clears `done`, `fail`, `fail_count`, `fail_addr`, `fail_elem` and `fail_bits` in the same edge.

## Timing
- Reset asserted (at any time, including mid-run): state goes to IDLE immediately. `busy`, `done`, `fail`, `fail_count`, `fail_addr`, `fail_elem` and `fail_bits` are all 0. The mux is in pass-through.
- `start` is sampled at edge k. `busy`=1 from edge k, and the first op is on `mem_*` in cycle k..k+1.
- Run lengths in RUN cycles:
  - MATS+: 5·wcount.
  - March X: 6·wcount.
  - March C-: 10·wcount.
- After RUN, there is one DRAIN cycle in which `busy` stays 1 while the last read is compared.
- `done`=1 and `busy`=0 at the next edge. `done` holds until the next accepted `start` or reset.
- Descending elements start at wcount-1 and end at 0. The address never wraps past 0 or past wcount-1.
- A read in the last op of an element is compared while the next element's first op is issued. Both proceed in the same cycle.

## Test plan
- March C-, solid, `wcount`=256, fault-free memory model → `busy` high 2561 cycles; `done`=1, `fail`=0, `fail_count`=0.
- March C-, solid, bit 1 of addr 0x2A stuck-at-1 → `fail`=1, `fail_addr`=0x2A, `fail_elem`=1, `fail_bits`=0010, `fail_count`=3.
- MATS+, checkerboard, fault-free → 1281 busy cycles. Bench monitor sees addr 0 written 0101 in e0 and addr 1 written 1010 in e0. `fail`=0.
- `wcount`=16, `fcw`=2, March C-, solid, memory model returns 0 on every read → `fail_elem`=2, `fail_addr`=0, `fail_count`=3 (saturated).
- `start` pulsed mid-run → ignored, run length unchanged. Then reset asserted mid-run → all outputs 0 and the functional write/read at addr 5 passes through to `mem_*` the same cycle. `mode`=11 after that → runs 10·wcount cycles.
- Second `start` in DONE after a failing run → diagnostics cleared at the accepting edge, and the fault-free rerun ends with `fail`=0.
